// File: rtl/proc_run_controller_if.sv
// Bundle between the run controller and its bench/board top and core: run control, PC/writeback observation, status.
// master = bench/core side, slave = controller.
interface proc_run_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [PC_W-1:0]  pc_in;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             core_reset;
    logic             run;
    logic             done;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] wb_count;
    logic [31:0]      signature;

    modport master (
        output start, pc_in, wb_en, wb_addr, wb_data,
        input  core_reset, run, done, halted, timeout, cycle_count, wb_count, signature
    );

    modport slave (
        input  start, pc_in, wb_en, wb_addr, wb_data,
        output core_reset, run, done, halted, timeout, cycle_count, wb_count, signature
    );
endinterface

// File: rtl/proc_run_controller.sv
// Purpose: hold MIPS core in reset, release it, detect halt (PC self-loop) or timeout; count cycles/writebacks.
// Latency: all outputs registered; RESET_HOLD lasts RST_CYCLES cycles; halt needs >= HALT_REPEAT+1 RUN cycles.
// Backpressure: none; start is only sampled in IDLE/DONE. Signature built when PROC_RUN_CTRL_SIGNATURE_EN is defined.
module proc_run_controller #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int MAX_CYCLES  = 1000,
    parameter int HALT_REPEAT = 3
) (
    input  logic                   ref_clk,
    input  logic                   reset,
    proc_run_controller_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int HOLD_W = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
    localparam int REP_W  = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [PC_W-1:0]  pc_prev;
    logic             pc_vld;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] wb_cnt;
    logic [31:0]      sig;
    logic             halted_q;
    logic             timeout_q;
    logic             run_q;
    logic             done_q;
    logic             core_reset_q;

    logic wb_acc;
    logic pc_match;
    logic halt_hit;
    logic tmo_hit;

    assign wb_acc   = (state == S_RUN) && bus.wb_en && (bus.wb_addr != 5'd0);
    assign pc_match = pc_vld && (bus.pc_in == pc_prev);
    // Repeat counter sits one below HALT_REPEAT on the deciding match.
    assign halt_hit = pc_match && (rep_cnt == REP_W'(HALT_REPEAT - 1));
    assign tmo_hit  = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_d = S_HOLD;
            S_HOLD:         if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) state_d = S_RUN;
            S_RUN:          if (halt_hit || tmo_hit) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state        <= S_IDLE;
            run_q        <= 1'b0;
            done_q       <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state        <= state_d;
            run_q        <= (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
            core_reset_q <= (state_d != S_RUN);
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            pc_prev   <= '0;
            pc_vld    <= 1'b0;
            cycle_cnt <= '0;
            wb_cnt    <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: hold_cnt <= '0;
                S_HOLD: begin
                    hold_cnt  <= hold_cnt + HOLD_W'(1);
                    rep_cnt   <= '0;
                    pc_vld    <= 1'b0;
                    cycle_cnt <= '0;
                    wb_cnt    <= '0;
                    halted_q  <= 1'b0;
                    timeout_q <= 1'b0;
                end
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    pc_prev   <= bus.pc_in;
                    pc_vld    <= 1'b1;
                    rep_cnt   <= pc_match ? rep_cnt + REP_W'(1) : '0;
                    if (wb_acc && !(&wb_cnt)) wb_cnt <= wb_cnt + CNT_W'(1);
                    // Halt wins over a coincident timeout.
                    if (halt_hit)     halted_q  <= 1'b1;
                    else if (tmo_hit) timeout_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PROC_RUN_CTRL_SIGNATURE_EN
    always_ff @(posedge ref_clk) begin
        if (reset || state == S_HOLD) begin
            sig <= '0;
        end else if (wb_acc) begin
            sig <= {sig[30:0], sig[31]} ^ bus.wb_data ^ {27'b0, bus.wb_addr};
        end
    end
`else
    assign sig = 32'h0;
`endif

    assign bus.core_reset  = core_reset_q;
    assign bus.run         = run_q;
    assign bus.done        = done_q;
    assign bus.halted      = halted_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_cnt;
    assign bus.wb_count    = wb_cnt;
    assign bus.signature   = sig;
endmodule

// File: doc/proc_run_controller.md
# proc_run_controller

Synthesizable run controller for the 32-bit MIPS core, replacing the hand-toggled clock and reset sequence in the processor bench. It holds the core in reset for a programmable number of cycles and then releases it. It detects program termination either as a PC self-loop (`j .`) or as a cycle-budget timeout, and reports cycle/writeback counts plus an optional writeback signature. It sits between the bench or board top and `PROCESSOR_32Bit`, driving the core's reset and observing `out_pc` and the write-back port.

## Interface
Parameters:
- `PC_W`, 32 — width of observed PC.
- `CNT_W`, 32 — width of cycle and writeback counters.
- `RST_CYCLES`, 4 — cycles `core_reset` is held in RESET_HOLD; must be ≥1.
- `MAX_CYCLES`, 1000 — RUN-cycle budget before timeout; must be ≥2.
- `HALT_REPEAT`, 3 — consecutive unchanged-PC cycles that declare a halt; must be ≥1.

Ports (clock and reset first):
- `ref_clk` in 1 — single clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — begin/restart a run; sampled in IDLE and DONE only.
- `pc_in` in PC_W — core PC (`out_pc`).
- `wb_en` in 1 — core register-file write enable.
- `wb_addr` in 5 — write-back register index.
- `wb_data` in 32 — write-back data (`out_mux_wb`).
- `core_reset` out 1 — reset to core; 1 in every state except RUN.
- `run` out 1 — 1 in RUN.
- `done` out 1 — 1 in DONE.
- `halted` out 1 — run ended on PC self-loop; valid while `done`.
- `timeout` out 1 — run ended on budget exhaustion; valid while `done`.
- `cycle_count` out CNT_W — RUN cycles elapsed.
- `wb_count` out CNT_W — accepted writebacks.
- `signature` out 32 — writeback signature.

## Operation
- States: IDLE, RESET_HOLD, RUN, DONE.
- IDLE → RESET_HOLD on `start`.
- RESET_HOLD lasts exactly RST_CYCLES cycles, then → RUN. It clears `cycle_count`, `wb_count`, `signature`, `halted`, `timeout`, the repeat counter and the PC-valid flag.
- RUN behaviour:
  - `cycle_count` increments every cycle.
  - First RUN cycle: captures `pc_in` into `pc_prev` and sets PC-valid; no comparison is made.
  - Later cycles compare `pc_in` with `pc_prev`. On a match the repeat counter increments; on a mismatch it clears. `pc_prev` updates every cycle.
- Halt: the cycle on which the repeat counter would reach HALT_REPEAT → DONE, with `halted`=1.
- Timeout: the cycle on which `cycle_count` would reach MAX_CYCLES with no halt → DONE, with `timeout`=1.
- Simultaneous halt and timeout: `halted`=1, `timeout`=0.
- Accepted writeback: `wb_en`=1, `wb_addr`≠0, state RUN. It increments `wb_count`; writebacks in other states or to `$0` are ignored.
- DONE holds all outputs; `start` → RESET_HOLD (restart). `start` is ignored in RESET_HOLD and RUN.
- Counter wrap: `cycle_count` cannot wrap because MAX_CYCLES < 2^CNT_W is required. `wb_count` saturates at all-ones.

## Timing
- Reset values: state IDLE, `core_reset`=1, `run`=0, `done`=0, `halted`=0, `timeout`=0, `cycle_count`=0, `wb_count`=0, `signature`=0.
- `reset` asserted mid-run: next edge returns to IDLE with the reset values; `core_reset` stays 1.
- All outputs are registered. `start` high at edge N gives `core_reset`=1 in RESET_HOLD from N+1 through N+RST_CYCLES, and `run`=1 from N+RST_CYCLES+1.
- Halt or timeout decided at edge M: `done`=1 and `core_reset`=1 from M+1. `cycle_count` includes the deciding cycle.
- Minimum halt latency: HALT_REPEAT+1 RUN cycles.

## Configuration
- `PROC_RUN_CTRL_SIGNATURE_EN` defined:
  - Each accepted writeback updates `signature` ← {`signature`[30:0], `signature`[31]} ^ `wb_data` ^ {27'b0, `wb_addr`}.
- Not defined:
  - No signature logic is built; `signature` is tied to 32'h0.
  - `wb_count` is unaffected.

## Test plan
- Reset then `start` pulse, with RST_CYCLES=4 → `core_reset`=1 for 4 cycles after start, then `run`=1; `cycle_count` counts 1, 2, 3, …
- PC sequence 0, 4, 8, 8, 8, 8 with HALT_REPEAT=3 → DONE after the third repeat of 8; `halted`=1, `timeout`=0, `cycle_count`=6.
- PC incrementing by 4 forever with MAX_CYCLES=20 → `timeout`=1, `halted`=0, `cycle_count`=20.
- Halt completion on exactly cycle MAX_CYCLES → `halted`=1, `timeout`=0.
- With the macro: writebacks (addr 1, 32'h0000_0005) then (addr 0, 32'hFFFF_FFFF) then (addr 2, 32'h0000_0010):
  - First writeback gives `signature`=32'h0000_0004.
  - The `$0` write is ignored.
  - Final `signature`=32'h0000_001A, `wb_count`=2.
  - Without the macro, `signature`=0 and `wb_count`=2.
- `reset` asserted during RUN at cycle 7 → next cycle IDLE with all reset values; a subsequent `start` gives a clean run from `cycle_count`=0.
